// File: rtl/mem_ctrl_arb_if.sv
// Request/response bundle between the I/D cache refill logic and mem_ctrl_arb.
interface mem_ctrl_arb_if #(
    parameter int ADDR_W = 20,
    parameter int LINE_W = 128
);
    logic              reqI_cache;
    logic              reqD_cache;
    logic              reqD_cache_write;
    logic [ADDR_W-1:0] reqAddrI_mem;
    logic [ADDR_W-1:0] reqAddrD_mem;
    logic [ADDR_W-1:0] reqAddrD_write_mem;
    logic [LINE_W-1:0] data_from_cache;
    logic [LINE_W-1:0] data_to_cache;
    logic              read_ready_for_icache;
    logic              read_ready_for_dcache;
    logic              written_data_ack;
    logic              busy;

    // cache side
    modport master (
        output reqI_cache, reqD_cache, reqD_cache_write,
        output reqAddrI_mem, reqAddrD_mem, reqAddrD_write_mem, data_from_cache,
        input  data_to_cache, read_ready_for_icache, read_ready_for_dcache,
        input  written_data_ack, busy
    );

    // controller side
    modport slave (
        input  reqI_cache, reqD_cache, reqD_cache_write,
        input  reqAddrI_mem, reqAddrD_mem, reqAddrD_write_mem, data_from_cache,
        output data_to_cache, read_ready_for_icache, read_ready_for_dcache,
        output written_data_ack, busy
    );
endinterface

// File: rtl/mem_ctrl_arb.sv
// Two-port (I-fetch / D-access) line controller in front of an internal RAM.
// Arbitrates I and D, runs D write-back + refill as one transaction, and
// returns lines after programmable read/write latencies.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting; grants a requester when no ready/ack pulse is high
// WRITE | counting down WR_LAT, commits latched line to RAM at cnt==0
// READ  | counting down RD_LAT, returns RAM line and pulses ready at cnt==0
module mem_ctrl_arb #(
    parameter int ADDR_W   = 20,
    parameter int LINE_W   = 128,
    parameter int IDX_W    = 10,
    parameter int RD_LAT   = 4,
    parameter int WR_LAT   = 4,
    parameter int ARB_MODE = 1
) (
    input  logic          clk,
    input  logic          reset,
    mem_ctrl_arb_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    localparam logic [3:0] RD_INIT = 4'(RD_LAT - 1);
    localparam logic [3:0] WR_INIT = 4'(WR_LAT - 1);

    state_t             state, state_nxt;
    logic [3:0]         cnt, cnt_nxt;
    logic               last_grant, last_grant_nxt;   // 1 = I served last
    logic [IDX_W-1:0]   rd_idx_q, wr_idx_q;
    logic [LINE_W-1:0]  wr_data_q, data_q;
    logic               rd_flag_q, side_i_q;
    logic               ack_q, rdy_i_q, rdy_d_q;
    logic               ack_nxt, rdy_i_nxt, rdy_d_nxt;
    logic               pend_i, pend_d, grant_i, grant_d, pulse_any;
    logic               ram_we, ram_re;
    logic [LINE_W-1:0]  ram [2**IDX_W];

    // Only the index bits address the RAM; upper address bits alias.
    logic unused_addr_hi;
    assign unused_addr_hi = ^{bus.reqAddrI_mem[ADDR_W-1:IDX_W],
                              bus.reqAddrD_mem[ADDR_W-1:IDX_W],
                              bus.reqAddrD_write_mem[ADDR_W-1:IDX_W]};

    assign pend_i    = bus.reqI_cache;
    assign pend_d    = bus.reqD_cache | bus.reqD_cache_write;
    assign pulse_any = ack_q | rdy_i_q | rdy_d_q;

    // Next-state, arbitration and pulse generation.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        last_grant_nxt = last_grant;
        grant_i        = 1'b0;
        grant_d        = 1'b0;
        ack_nxt        = 1'b0;
        rdy_i_nxt      = 1'b0;
        rdy_d_nxt      = 1'b0;
        ram_we         = 1'b0;
        ram_re         = 1'b0;
        unique case (state)
            IDLE: begin
                // A pulse cycle is a dead cycle so the requester can drop its level.
                if (!pulse_any) begin
                    if (ARB_MODE == 0) begin
                        grant_d = pend_d;
                        grant_i = pend_i & ~pend_d;
                    end else if (pend_i && pend_d) begin
                        grant_d = last_grant;
                        grant_i = ~last_grant;
                    end else begin
                        grant_d = pend_d;
                        grant_i = pend_i;
                    end
                    if (grant_d) begin
                        last_grant_nxt = 1'b0;
                        if (bus.reqD_cache_write) begin
                            state_nxt = WRITE;
                            cnt_nxt   = WR_INIT;
                        end else begin
                            state_nxt = READ;
                            cnt_nxt   = RD_INIT;
                        end
                    end else if (grant_i) begin
                        last_grant_nxt = 1'b1;
                        state_nxt      = READ;
                        cnt_nxt        = RD_INIT;
                    end
                end
            end
            WRITE: begin
                if (cnt == 4'd0) begin
                    ram_we  = 1'b1;
                    ack_nxt = 1'b1;
                    if (rd_flag_q) begin
                        state_nxt = READ;
                        cnt_nxt   = RD_INIT;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            READ: begin
                if (cnt == 4'd0) begin
                    ram_re    = 1'b1;
                    rdy_i_nxt = side_i_q;
                    rdy_d_nxt = ~side_i_q;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register, operand latches at grant, and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= 1'b1;
            rd_idx_q   <= '0;
            wr_idx_q   <= '0;
            wr_data_q  <= '0;
            rd_flag_q  <= 1'b0;
            side_i_q   <= 1'b0;
            ack_q      <= 1'b0;
            rdy_i_q    <= 1'b0;
            rdy_d_q    <= 1'b0;
            data_q     <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            last_grant <= last_grant_nxt;
            ack_q      <= ack_nxt;
            rdy_i_q    <= rdy_i_nxt;
            rdy_d_q    <= rdy_d_nxt;
            if (grant_i) begin
                rd_idx_q  <= bus.reqAddrI_mem[IDX_W-1:0];
                rd_flag_q <= 1'b1;
                side_i_q  <= 1'b1;
            end
            if (grant_d) begin
                rd_idx_q  <= bus.reqAddrD_mem[IDX_W-1:0];
                wr_idx_q  <= bus.reqAddrD_write_mem[IDX_W-1:0];
                wr_data_q <= bus.data_from_cache;
                rd_flag_q <= bus.reqD_cache;
                side_i_q  <= 1'b0;
            end
            if (ram_re) begin
                data_q <= ram[rd_idx_q];
            end
        end
    end

    // Line storage; never cleared, and only written from WRITE (IDLE while in reset).
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[wr_idx_q] <= wr_data_q;
        end
    end

    assign bus.data_to_cache         = data_q;
    assign bus.read_ready_for_icache = rdy_i_q;
    assign bus.read_ready_for_dcache = rdy_d_q;
    assign bus.written_data_ack      = ack_q;
    assign bus.busy                  = (state != IDLE);
endmodule

// File: tb/tb_mem_ctrl_arb.sv
// Bench for mem_ctrl_arb: a round-robin instance with default latencies and a
// fixed-priority instance with unit latencies, checked through a scoreboard.
`timescale 1ns/1ps
module tb_mem_ctrl_arb;
    localparam int AW = 20;
    localparam int LW = 128;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_ctrl_arb_if #(.ADDR_W(AW), .LINE_W(LW)) bus_rr ();
    mem_ctrl_arb_if #(.ADDR_W(AW), .LINE_W(LW)) bus_fx ();

    mem_ctrl_arb #(.ARB_MODE(1), .RD_LAT(4), .WR_LAT(4)) u_rr (
        .clk(clk), .reset(reset), .bus(bus_rr)
    );
    mem_ctrl_arb #(.ARB_MODE(0), .RD_LAT(1), .WR_LAT(1)) u_fx (
        .clk(clk), .reset(reset), .bus(bus_fx)
    );

    logic          req_i [2], req_d [2], req_w [2];
    logic [AW-1:0] a_i [2], a_d [2], a_w [2];
    logic [LW-1:0] wdat [2];
    logic          p_ack [2], p_ri [2], p_rd [2], bsy [2];
    logic [LW-1:0] dout [2];

    assign bus_rr.reqI_cache         = req_i[0];
    assign bus_rr.reqD_cache         = req_d[0];
    assign bus_rr.reqD_cache_write   = req_w[0];
    assign bus_rr.reqAddrI_mem       = a_i[0];
    assign bus_rr.reqAddrD_mem       = a_d[0];
    assign bus_rr.reqAddrD_write_mem = a_w[0];
    assign bus_rr.data_from_cache    = wdat[0];
    assign bus_fx.reqI_cache         = req_i[1];
    assign bus_fx.reqD_cache         = req_d[1];
    assign bus_fx.reqD_cache_write   = req_w[1];
    assign bus_fx.reqAddrI_mem       = a_i[1];
    assign bus_fx.reqAddrD_mem       = a_d[1];
    assign bus_fx.reqAddrD_write_mem = a_w[1];
    assign bus_fx.data_from_cache    = wdat[1];

    assign p_ack[0] = bus_rr.written_data_ack;
    assign p_ri[0]  = bus_rr.read_ready_for_icache;
    assign p_rd[0]  = bus_rr.read_ready_for_dcache;
    assign bsy[0]   = bus_rr.busy;
    assign dout[0]  = bus_rr.data_to_cache;
    assign p_ack[1] = bus_fx.written_data_ack;
    assign p_ri[1]  = bus_fx.read_ready_for_icache;
    assign p_rd[1]  = bus_fx.read_ready_for_dcache;
    assign bsy[1]   = bus_fx.busy;
    assign dout[1]  = bus_fx.data_to_cache;

    // kind: 0 = write ack, 1 = I ready, 2 = D ready; cyc < 0 means timing not checked
    typedef struct {
        int          inst;
        int          kind;
        logic [LW-1:0] data;
        int          cyc;
    } exp_t;

    exp_t sb [$];
    int   errors = 0;
    int   checks = 0;
    bit   last_was_i [2];

    task automatic check_val(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int rd_lat(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    function automatic int wr_lat(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    function automatic logic [LW-1:0] pat(input logic [AW-1:0] a);
        logic [31:0] w;
        w = {12'hC0D, a};
        return {w, ~w, w ^ 32'h5A5A_A5A5, w + 32'd7};
    endfunction

    task automatic idle_inputs(input int d);
        req_i[d] = 1'b0;
        req_d[d] = 1'b0;
        req_w[d] = 1'b0;
        a_i[d]   = '0;
        a_d[d]   = '0;
        a_w[d]   = '0;
        wdat[d]  = '0;
    endtask

    task automatic check_quiet(input int d, input string tag);
        check_val({tag, "_busy"}, bsy[d], 0);
        check_val({tag, "_ack"}, p_ack[d], 0);
        check_val({tag, "_rdy_i"}, p_ri[d], 0);
        check_val({tag, "_rdy_d"}, p_rd[d], 0);
        check_val({tag, "_data"}, dout[d], 0);
    endtask

    // Pulse monitor: every pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int   n;
            int   k;
            exp_t e;
            n = int'(p_ack[d]) + int'(p_ri[d]) + int'(p_rd[d]);
            if (n > 1) check_val("one_pulse", n, 1);
            if (n == 1) begin
                k = p_ack[d] ? 0 : (p_ri[d] ? 1 : 2);
                if (sb.size() == 0) begin
                    check_val("unexpected_pulse", n, 0);
                end else begin
                    e = sb.pop_front();
                    check_val("pulse_inst", d, e.inst);
                    check_val("pulse_kind", k, e.kind);
                    if (e.kind != 0) check_val("line_data", dout[d], e.data);
                    if (e.cyc >= 0) check_val("pulse_cycle", cyc, e.cyc);
                end
            end
        end
    end

    // One transaction from an idle DUT; operands are scrambled right after grant.
    task automatic txn(input int d, input bit side_i, input bit rd, input bit wr,
                       input logic [AW-1:0] ra, input logic [AW-1:0] wa,
                       input logic [LW-1:0] wd, input logic [LW-1:0] expd);
        int   g;
        int   t_ack;
        int   t_end;
        bit   done;
        exp_t e;
        @(negedge clk);
        g = cyc;
        if (side_i) begin
            req_i[d] = 1'b1;
            a_i[d]   = ra;
        end else begin
            req_d[d] = rd;
            req_w[d] = wr;
            a_d[d]   = ra;
            a_w[d]   = wa;
            wdat[d]  = wd;
        end
        t_ack = g + wr_lat(d) + 1;
        t_end = rd ? g + (wr ? wr_lat(d) : 0) + rd_lat(d) + 1 : t_ack;
        if (wr) begin
            e.inst = d; e.kind = 0; e.data = '0; e.cyc = t_ack;
            sb.push_back(e);
        end
        if (rd) begin
            e.inst = d; e.kind = side_i ? 1 : 2; e.data = expd; e.cyc = t_end;
            sb.push_back(e);
        end
        last_was_i[d] = side_i;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (cyc == g + 1) begin
                a_i[d]  = AW'($urandom);
                a_d[d]  = AW'($urandom);
                a_w[d]  = AW'($urandom);
                wdat[d] = {$urandom, $urandom, $urandom, $urandom};
            end
            check_val("busy", bsy[d], (cyc > g && cyc < t_end));
            if (rd ? (p_ri[d] || p_rd[d]) : p_ack[d]) done = 1'b1;
        end
        check_val("txn_done", done, 1);
        idle_inputs(d);
    endtask

    // I and D both keep requesting n lines back to back.
    task automatic stream(input int d, input bit rr, input int n,
                          input logic [AW-1:0] ibase, input logic [AW-1:0] dbase);
        int   g;
        int   ni;
        int   nd;
        bit   first_d;
        bit   take_d;
        exp_t e;
        @(negedge clk);
        g = cyc;
        req_i[d] = 1'b1;
        a_i[d]   = ibase;
        req_d[d] = 1'b1;
        a_d[d]   = dbase;
        first_d  = rr ? last_was_i[d] : 1'b1;
        take_d   = first_d;
        ni = 0;
        nd = 0;
        for (int k = 0; k < 2 * n; k++) begin
            if (rr) take_d = (k % 2 == 0) ? first_d : !first_d;
            else    take_d = (nd < n);
            e.inst = d;
            e.kind = take_d ? 2 : 1;
            e.data = take_d ? pat(dbase + AW'(nd)) : pat(ibase + AW'(ni));
            e.cyc  = g + k * (rd_lat(d) + 2) + rd_lat(d) + 1;
            sb.push_back(e);
            if (take_d) nd++;
            else        ni++;
        end
        last_was_i[d] = !take_d;
        ni = 0;
        nd = 0;
        for (int i = 0; i < 400 && (ni < n || nd < n); i++) begin
            @(negedge clk);
            if (p_ri[d]) begin
                ni++;
                if (ni < n) a_i[d] = ibase + AW'(ni);
                else        req_i[d] = 1'b0;
            end
            if (p_rd[d]) begin
                nd++;
                if (nd < n) a_d[d] = dbase + AW'(nd);
                else        req_d[d] = 1'b0;
            end
        end
        check_val("stream_done", ni + nd, 2 * n);
        idle_inputs(d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish by 200000ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [LW-1:0] line_a5;
        logic [LW-1:0] line_db;
        logic [LW-1:0] line_x;
        logic [LW-1:0] line_y;
        line_a5 = {16{8'hA5}};
        line_db = 128'hDEAD_C0DE_0123_4567_89AB_CDEF_F00D_BEEF;
        line_x  = 128'h1357_9BDF_0246_8ACE_FEDC_BA98_7654_3210;
        line_y  = 128'h0F0F_0F0F_F0F0_F0F0_3C3C_3C3C_C3C3_C3C3;
        idle_inputs(0);
        idle_inputs(1);

        #2 reset = 1'b0;
        #1;
        check_quiet(0, "rst_rr");
        check_quiet(1, "rst_fx");
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // round-robin instance, RD_LAT = WR_LAT = 4
        txn(0, 0, 0, 1, '0, 20'h00010, line_a5, '0);
        txn(0, 1, 1, 0, 20'h00010, '0, '0, line_a5);
        txn(0, 0, 1, 1, 20'h00020, 20'h00020, line_db, line_db);
        for (int k = 0; k < 4; k++) begin
            txn(0, 0, 0, 1, '0, 20'h00040 + AW'(k), pat(20'h00040 + AW'(k)), '0);
            txn(0, 0, 0, 1, '0, 20'h00048 + AW'(k), pat(20'h00048 + AW'(k)), '0);
        end
        txn(0, 0, 0, 1, '0, 20'h00455, line_y, '0);
        txn(0, 1, 1, 0, 20'h00055, '0, '0, line_y);
        txn(0, 0, 0, 1, '0, 20'h00030, line_x, '0);

        // reset in the middle of a READ
        @(negedge clk);
        req_d[0] = 1'b1;
        a_d[0]   = 20'h00030;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check_quiet(0, "abort_rd");
        idle_inputs(0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);

        // reset in the middle of a WRITE: RAM must keep the old line
        req_w[0] = 1'b1;
        a_w[0]   = 20'h00030;
        wdat[0]  = line_a5;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check_quiet(0, "abort_wr");
        idle_inputs(0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        txn(0, 1, 1, 0, 20'h00030, '0, '0, line_x);

        stream(0, 1, 4, 20'h00040, 20'h00048);

        // fixed-priority instance, RD_LAT = WR_LAT = 1
        for (int k = 0; k < 4; k++) begin
            txn(1, 0, 0, 1, '0, 20'h00040 + AW'(k), pat(20'h00040 + AW'(k)), '0);
            txn(1, 0, 0, 1, '0, 20'h00048 + AW'(k), pat(20'h00048 + AW'(k)), '0);
        end
        txn(1, 1, 1, 0, 20'h00041, '0, '0, pat(20'h00041));
        txn(1, 0, 1, 1, 20'h00020, 20'h00020, line_db, line_db);
        stream(1, 0, 4, 20'h00040, 20'h00048);

        repeat (4) @(negedge clk);
        check_val("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_ctrl_arb.md
Name: mem_ctrl_arb

Overview:
Parametrised successor of the two-port cache-to-memory controller. It sits between the I-cache/D-cache refill logic and an internal line-wide RAM array. It arbitrates I-fetch and D-access requests with a selectable policy, and supports D-side write-back followed by refill as a single transaction. Read and write latencies are programmable, and all request operands are latched at grant.

Parameters:
ADDR_W, 20, line address width of every address port
LINE_W, 128, cache line width in bits
IDX_W, 10, index bits; RAM depth = 2**IDX_W lines, indexed by addr[IDX_W-1:0]
RD_LAT, 4, cycles from grant to read data return (legal range 1..15)
WR_LAT, 4, cycles from write start to write commit (legal range 1..15)
ARB_MODE, 1, 0 = fixed D-priority, 1 = round-robin between I and D

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
reqI_cache  in  1  I-cache line read request, level, held until read_ready_for_icache
reqD_cache  in  1  D-cache line read request, level, held until read_ready_for_dcache
reqD_cache_write  in  1  D-cache write-back request, level, held until written_data_ack
reqAddrI_mem  in  ADDR_W  I-side read line address
reqAddrD_mem  in  ADDR_W  D-side read line address
reqAddrD_write_mem  in  ADDR_W  D-side write-back line address
data_from_cache  in  LINE_W  write-back line data
data_to_cache  out  LINE_W  returned line, valid while a ready pulse is high
read_ready_for_icache  out  1  one-cycle pulse: I read complete
read_ready_for_dcache  out  1  one-cycle pulse: D read complete
written_data_ack  out  1  one-cycle pulse: write-back committed
busy  out  1  high in any state other than IDLE

Behaviour:
- States: IDLE, WRITE, READ.
- 4-bit down-counter cnt; last_grant bit (0 = D, 1 = I).
- Reset (reset low, asynchronous):
  - state = IDLE, cnt = 0, last_grant = 1.
  - All outputs are 0, including data_to_cache.
  - RAM contents are not cleared.
  - Reset asserted mid-transaction aborts it: no ack/ready pulse, and a WRITE not yet committed does not modify the RAM.
- IDLE:
  - Grant is evaluated only when no ready/ack pulse is high in that cycle; that cycle is a mandatory dead cycle for requester deassertion.
  - D pending = reqD_cache | reqD_cache_write.
  - ARB_MODE=0: D wins whenever pending.
  - ARB_MODE=1: if both I and D pending, the side opposite last_grant wins; a single pending side always wins.
  - On grant, latch:
    - I grant: reqAddrI_mem.
    - D grant: reqAddrD_mem, reqAddrD_write_mem, data_from_cache, and the write/read flags.
  - On grant, update last_grant.
  - Next state: WRITE with cnt = WR_LAT-1 if the D write flag is set; otherwise READ with cnt = RD_LAT-1.
- WRITE:
  - cnt decrements each cycle.
  - At cnt==0: write the latched data into RAM[latched wr addr] and pulse written_data_ack for the next cycle.
  - Then go to READ (cnt = RD_LAT-1) if the latched D read flag is set, else IDLE.
- READ:
  - cnt decrements each cycle.
  - At cnt==0: load data_to_cache = RAM[latched rd addr], pulse the granted side's ready for one cycle, and go to IDLE.
- data_to_cache holds its value until the next read completes.
- Latency:
  - Read-only: ready is high in cycle G+RD_LAT+1, where G is the grant edge cycle.
  - Write+read: ack is high in cycle G+WR_LAT+1, ready in cycle G+WR_LAT+RD_LAT+1.
- Read after write to the same index within one transaction returns the newly written line.
- Inputs that change after grant are ignored until the next grant.
- Never more than one of the three pulses is high in a cycle.
- Addresses wider than IDX_W alias modulo 2**IDX_W.

Test Plan:
1. Reset low mid-READ → all outputs 0 immediately; after release, no stale ready pulse; RAM unchanged.
2. Default params. reqI_cache=1, addr 0x00010, RAM[0x010]=A5A5…; grant at cycle 1 → read_ready_for_icache high in cycle 6 only, data_to_cache=A5A5…; busy high cycles 2–5.
3. reqD_cache_write=1 and reqD_cache=1, write addr 0x00020 with data 0xDEAD…BEEF, read addr 0x00020 → written_data_ack in cycle G+5, read_ready_for_dcache in cycle G+9, data_to_cache=0xDEAD…BEEF.
4. ARB_MODE=1, reqI_cache and reqD_cache held high continuously (each deasserting one cycle after its own ready) → grants alternate I, D, I, D; no ready pulse is ever missed.
5. ARB_MODE=0, same stimulus as scenario 4 → D granted every time D is pending; I served only after D drops.
6. RD_LAT=1, WR_LAT=1, back-to-back requests → read ready at G+2; no grant in the cycle a pulse is high; reqAddrI_mem changed after grant has no effect on returned data.
